// File: rtl/switch_pkg.sv
// Shared types and default timing constants for the slide-switch conditioner.
// Cycle counts assume the 10 MHz system clock.
package switch_pkg;

    // Per-channel debounce state.
    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } debounce_state_t;

    localparam int CLK_HZ                   = 10_000_000;
    localparam int SYNC_STAGES_DEFAULT      = 2;
    // 10 ms of consecutive disagreeing samples flips a debounced level.
    localparam int DEBOUNCE_CYCLES_10MS     = CLK_HZ / 100;
    // 100 us of a stable pair before it is handed to the mode FSM.
    localparam int PAIR_SETTLE_CYCLES_100US = CLK_HZ / 10_000;

endpackage

// File: rtl/switch_debounce.sv
// One switch channel: synchroniser chain followed by an IDLE/PENDING debouncer.
// `level` is the registered debounced level; `level_next` is the value it takes
// at the coming edge, so the pair stage can see a flip in the cycle it happens.
module switch_debounce
    import switch_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_10MS
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic level_next
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] COUNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   synced;

    debounce_state_t state_reg;
    debounce_state_t state_next;
    logic [CW-1:0]   count_reg;
    logic [CW-1:0]   count_next;
    logic            level_reg;

    // Shift the asynchronous pin through the synchroniser chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
        end
    end

    assign synced = sync_reg[SYNC_STAGES-1];

    // Debounce state, disagreement counter and debounced level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            count_reg <= '0;
            level_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            level_reg <= level_next;
        end
    end

    // Count consecutive disagreeing samples; any agreeing sample restarts from zero.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        level_next = level_reg;
        case (state_reg)
            IDLE: begin
                count_next = '0;
                if (synced != level_reg) begin
                    state_next = PENDING;
                    count_next = CW'(1);
                end
            end
            PENDING: begin
                if (synced == level_reg) begin
                    state_next = IDLE;
                    count_next = '0;
                end else if (count_reg == COUNT_LAST) begin
                    state_next = IDLE;
                    count_next = '0;
                    level_next = ~level_reg;
                end else begin
                    count_next = count_reg + CW'(1);
                end
            end
        endcase
    end

    assign level = level_reg;

endmodule

// File: rtl/switch_conditioner.sv
// Conditions the right/left slide switches for the mode-select FSM:
// synchronise, debounce, then present {left,right} with a one-cycle change strobe.
// Optional feature: define SWITCH_PAIR_LOCK_EN to add the pair-settle stage, which
// holds a new pair back until it has been stable, so a two-switch move reaches the
// mode FSM as a single transition.
module switch_conditioner
    import switch_pkg::*;
#(
    parameter int SYNC_STAGES        = SYNC_STAGES_DEFAULT,
    parameter int DEBOUNCE_CYCLES    = DEBOUNCE_CYCLES_10MS,
    parameter int PAIR_SETTLE_CYCLES = PAIR_SETTLE_CYCLES_100US
) (
    input  logic clk,
    input  logic reset_n,
    input  logic right_raw,
    input  logic left_raw,
    output logic right,
    output logic left,
    output logic change_pulse
);

    // Bit 0 is the right switch, bit 1 the left switch.
    logic [1:0] raw_pair;
    logic [1:0] deb_pair;
    logic [1:0] deb_pair_next;

    logic [1:0] out_reg;
    logic [1:0] out_next;
    logic       pulse_reg;
    logic       pulse_next;

    assign raw_pair = {left_raw, right_raw};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            switch_debounce #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk        (clk),
                .reset_n    (reset_n),
                .raw        (raw_pair[gi]),
                .level      (deb_pair[gi]),
                .level_next (deb_pair_next[gi])
            );
        end
    endgenerate

`ifdef SWITCH_PAIR_LOCK_EN
    localparam int SW = $clog2(PAIR_SETTLE_CYCLES);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(PAIR_SETTLE_CYCLES - 1);

    logic [SW-1:0] settle_reg;
    logic [SW-1:0] settle_next;

    // Settle counter for the pending pair.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            settle_reg <= '0;
        end else begin
            settle_reg <= settle_next;
        end
    end

    // Release a new pair only after it has held still for the settle time;
    // any movement of either channel restarts the wait.
    always_comb begin
        out_next    = out_reg;
        pulse_next  = 1'b0;
        settle_next = settle_reg;
        if (deb_pair_next == out_reg) begin
            settle_next = '0;
        end else if (deb_pair_next != deb_pair) begin
            settle_next = '0;
        end else if (settle_reg == SETTLE_LAST) begin
            out_next    = deb_pair_next;
            pulse_next  = 1'b1;
            settle_next = '0;
        end else begin
            settle_next = settle_reg + SW'(1);
        end
    end
`else
    // The look-ahead level and settle time only matter for the pair-settle stage.
    logic [1:0]  unused_deb_next;
    logic [31:0] unused_settle;
    assign unused_deb_next = deb_pair_next;
    assign unused_settle   = 32'(PAIR_SETTLE_CYCLES);

    // Plain output register: follow the debounced pair, strobe on any difference.
    always_comb begin
        out_next   = deb_pair;
        pulse_next = (deb_pair != out_reg);
    end
`endif

    // Output pair and change strobe registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_reg   <= 2'b00;
            pulse_reg <= 1'b0;
        end else begin
            out_reg   <= out_next;
            pulse_reg <= pulse_next;
        end
    end

    assign right        = out_reg[0];
    assign left         = out_reg[1];
    assign change_pulse = pulse_reg;

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// PAIR_SETTLE_CYCLES=3. Follows SWITCH_PAIR_LOCK_EN when it is defined.
module tb_switch_conditioner;

    localparam int S = 2;
    localparam int D = 4;
    localparam int P = 3;
`ifdef SWITCH_PAIR_LOCK_EN
    localparam int LAT = S + D + P;
`else
    localparam int LAT = S + D + 1;
`endif

    logic clk;
    logic reset_n;
    logic right_raw;
    logic left_raw;
    logic right;
    logic left;
    logic change_pulse;

    int total;
    int bad;

    switch_conditioner #(
        .SYNC_STAGES        (S),
        .DEBOUNCE_CYCLES    (D),
        .PAIR_SETTLE_CYCLES (P)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .right_raw    (right_raw),
        .left_raw     (left_raw),
        .right        (right),
        .left         (left),
        .change_pulse (change_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Synced value = raw sampled S edges earlier; a level flips after D
    // consecutive disagreeing synced samples; the output follows one edge later,
    // or (with the lock) once the debounced pair has been unchanged for P edges.
    logic [1:0] m_hist[$];
    logic [1:0] m_lvl;
    int         m_streak[2];
    logic [1:0] m_out;
    logic       m_pulse;
`ifdef SWITCH_PAIR_LOCK_EN
    logic [1:0] m_deb_prev;
    int         m_stable;
`endif

    task automatic model_reset();
        m_hist.delete();
        m_lvl       = 2'b00;
        m_streak[0] = 0;
        m_streak[1] = 0;
        m_out       = 2'b00;
        m_pulse     = 1'b0;
`ifdef SWITCH_PAIR_LOCK_EN
        m_deb_prev  = 2'b00;
        m_stable    = 0;
`endif
    endtask

    task automatic model_step(input logic [1:0] raw);
        logic [1:0] synced;
        logic [1:0] lvl_pre;
        synced = (m_hist.size() >= S) ? m_hist[S-1] : 2'b00;
        m_hist.push_front(raw);
        if (m_hist.size() > S) void'(m_hist.pop_back());
        lvl_pre = m_lvl;
        for (int i = 0; i < 2; i++) begin
            if (synced[i] != lvl_pre[i]) begin
                m_streak[i]++;
                if (m_streak[i] == D) begin
                    m_lvl[i]    = ~m_lvl[i];
                    m_streak[i] = 0;
                end
            end else begin
                m_streak[i] = 0;
            end
        end
`ifdef SWITCH_PAIR_LOCK_EN
        if (m_lvl == m_deb_prev) begin
            if (m_stable < 1000) m_stable++;
        end else begin
            m_stable = 0;
        end
        m_deb_prev = m_lvl;
        if (m_lvl != m_out && m_stable >= P) begin
            m_out   = m_lvl;
            m_pulse = 1'b1;
        end else begin
            m_pulse = 1'b0;
        end
`else
        m_pulse = (lvl_pre != m_out);
        m_out   = lvl_pre;
`endif
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // One clock edge with the given raw levels; compares against the model.
    task automatic cycle(input logic r, input logic l, output logic [1:0] pair, output logic p);
        right_raw = r;
        left_raw  = l;
        @(posedge clk);
        model_step({l, r});
        @(negedge clk);
        pair = {left, right};
        p    = change_pulse;
        check("model", int'({left, right, change_pulse}), int'({m_out, m_pulse}));
    endtask

    // Reset for two cycles with the given raw levels, released on a falling edge.
    task automatic do_reset(input logic r, input logic l);
        right_raw = r;
        left_raw  = l;
        reset_n   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_hold", int'({left, right, change_pulse}), 0);
        model_reset();
        reset_n = 1'b1;
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic       r;
        logic       l;
        int         hold;
        logic [1:0] exp_pair;
        int         exp_pulses;
    } vec_t;

    vec_t vecs[9];

    logic [1:0] pair;
    logic       p;
    int         np;
    bit         saw_10;
    logic       rr;
    logic       rl;
    int         hold;

    initial begin
        total     = 0;
        bad       = 0;
        reset_n   = 1'b0;
        right_raw = 1'b1;
        left_raw  = 1'b1;
        model_reset();

        vecs[0] = '{1'b0, 1'b0, 10, 2'b00, 0};
        vecs[1] = '{1'b1, 1'b0, 10, 2'b01, 1};
        vecs[2] = '{1'b1, 1'b1, 10, 2'b11, 1};
        vecs[3] = '{1'b0, 1'b1, 10, 2'b10, 1};
        vecs[4] = '{1'b0, 1'b0, 10, 2'b00, 1};
        vecs[5] = '{1'b1, 1'b1, 10, 2'b11, 1};
        vecs[6] = '{1'b0, 1'b0,  3, 2'b11, 0};
        vecs[7] = '{1'b1, 1'b1, 10, 2'b11, 0};
        vecs[8] = '{1'b0, 1'b0, 10, 2'b00, 1};

        // Reset state with both pins high.
        @(negedge clk);
        check("reset_state", int'({left, right, change_pulse}), 0);
        $display("reset: out=%b%b pulse=%b", left, right, change_pulse);

        // Scenario 1: release reset with right held high.
        do_reset(1'b1, 1'b0);
        np = 0;
        for (int e = 1; e <= LAT + 3; e++) begin
            cycle(1'b1, 1'b0, pair, p);
            np += int'(p);
            check("s1_edge", int'({pair, p}), int'({1'b0, (e >= LAT), (e == LAT)}));
        end
        check("s1_pulses", np, 1);
        $display("s1 right after reset: out=%b pulses=%0d", pair, np);

        // Scenario 2: bounce every two cycles, then hold high.
        do_reset(1'b0, 1'b0);
        for (int c = 0; c < 20; c++) begin
            cycle(((c / 2) % 2) == 0, 1'b0, pair, p);
            check("s2_bounce", int'({pair, p}), 0);
        end
        for (int h = 0; h < LAT + 3; h++) begin
            cycle(1'b1, 1'b0, pair, p);
            check("s2_hold", int'({pair, p}), int'({1'b0, (h >= LAT - 1), (h == LAT - 1)}));
        end
        $display("s2 bounce then hold: out=%b", pair);

        // Scenario 3: 3-cycle glitch on left never propagates.
        do_reset(1'b0, 1'b0);
        for (int c = 0; c < 15; c++) begin
            cycle(1'b0, c < 3, pair, p);
            check("s3_glitch", int'({pair, p}), 0);
        end
        $display("s3 left glitch: out=%b", pair);

        // Scenario 4: left rises, right rises two cycles later.
        do_reset(1'b0, 1'b0);
        np     = 0;
        saw_10 = 1'b0;
        for (int c = 0; c < 16; c++) begin
            cycle(c >= 2, 1'b1, pair, p);
            np += int'(p);
            if (pair == 2'b10) saw_10 = 1'b1;
        end
        check("s4_final", int'(pair), 3);
`ifdef SWITCH_PAIR_LOCK_EN
        check("s4_pulses", np, 1);
        check("s4_saw_10", int'(saw_10), 0);
`else
        check("s4_pulses", np, 2);
        check("s4_saw_10", int'(saw_10), 1);
`endif
        $display("s4 staggered pair: out=%b pulses=%0d saw_10=%0d", pair, np, saw_10);

        // Scenario 5: reset while right pending and left high.
        do_reset(1'b0, 1'b0);
        for (int c = 0; c < 10; c++) cycle(1'b0, 1'b1, pair, p);
        check("s5_left_up", int'(pair), 2);
        for (int c = 0; c < 4; c++) cycle(1'b1, 1'b1, pair, p);
        check("s5_pending", int'({pair, p}), int'({2'b10, 1'b0}));
        #2 reset_n = 1'b0;
        #1;
        check("s5_async", int'({left, right, change_pulse}), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        np = 0;
        for (int e = 1; e <= LAT + 3; e++) begin
            cycle(1'b1, 1'b1, pair, p);
            np += int'(p);
            check("s5_edge", int'({pair, p}), int'({(e >= LAT), (e >= LAT), (e == LAT)}));
        end
        check("s5_pulses", np, 1);
        $display("s5 reset mid-count: out=%b pulses=%0d", pair, np);

        // Table vectors, applied from a clean reset.
        do_reset(1'b0, 1'b0);
        for (int v = 0; v < 9; v++) begin
            np = 0;
            for (int c = 0; c < vecs[v].hold; c++) begin
                cycle(vecs[v].r, vecs[v].l, pair, p);
                np += int'(p);
            end
            check("vec_pair", int'(pair), int'(vecs[v].exp_pair));
            check("vec_pulses", np, vecs[v].exp_pulses);
            $display("vec %0d raw=%b%b hold=%0d out=%b pulses=%0d",
                     v, vecs[v].l, vecs[v].r, vecs[v].hold, pair, np);
        end

        // Random segments against the model.
        for (int seg = 0; seg < 60; seg++) begin
            rr   = 1'($urandom_range(0, 1));
            rl   = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 12);
            np   = 0;
            for (int c = 0; c < hold; c++) begin
                cycle(rr, rl, pair, p);
                np += int'(p);
            end
            $display("seg %0d raw=%b%b hold=%0d out=%b pulses=%0d", seg, rl, rr, hold, pair, np);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
